// File: rtl/cry_pkg.sv
// -----------------------------------------------------------------------------
// cry_pkg
// Shared constants for the CRY/RGB16 to RGB888 conversion pipeline:
//   - bit positions of the CRY and RGB16 fields inside a 16-bit pixel
//   - format-select encodings carried with every pixel
//   - pipeline depth
//   - 5/6-bit to 8-bit component expansion helpers (bit replication)
// -----------------------------------------------------------------------------
package cry_pkg;

    localparam int LAT = 3;

    localparam int CRY_IDX_MSB = 15;
    localparam int CRY_IDX_LSB = 8;
    localparam int CRY_Y_MSB   = 7;
    localparam int CRY_Y_LSB   = 0;

    localparam int RGB16_R_MSB = 15;
    localparam int RGB16_R_LSB = 11;
    localparam int RGB16_B_MSB = 10;
    localparam int RGB16_B_LSB = 6;
    localparam int RGB16_G_MSB = 5;
    localparam int RGB16_G_LSB = 0;

    localparam logic MODE_CRY   = 1'b1;
    localparam logic MODE_RGB16 = 1'b0;

    // Replicating the top bits into the new LSBs maps 0 -> 0x00 and max -> 0xFF.
    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction

endpackage

// File: rtl/cry_scale.sv
// -----------------------------------------------------------------------------
// cry_scale
// Combinational intensity scaling: unsigned 8x8 multiply, result bits [15:8]
// (truncated, no rounding).
// Ports:
//   i_comp  in  8  colour component from the CRY ROM
//   i_y     in  8  Y intensity
//   o_comp  out 8  scaled component
// -----------------------------------------------------------------------------
module cry_scale (
    input  logic [7:0] i_comp,
    input  logic [7:0] i_y,
    output logic [7:0] o_comp
);

    logic [15:0] w_prod;

    assign w_prod = 16'(i_comp) * 16'(i_y);
    assign o_comp = w_prod[15:8];

endmodule

// File: rtl/cry_rgb_conv.sv
// -----------------------------------------------------------------------------
// cry_rgb_conv
// Three-stage pixel conversion pipeline placed after the 256x8 CRY ROMs.
// CRY pixels look up the colour index in the external ROMs and scale each
// component by Y; RGB16 pixels are expanded to RGB888 by bit replication.
// The whole pipeline advances together under a valid/ready handshake.
// Ports:
//   sys_clk              in   1   clock (rising edge)
//   rst                  in   1   asynchronous active-high reset
//   cry_mode             in   1   1 = CRY, 0 = RGB16, sampled per pixel
//   pix_valid/pix_ready  in/out   input handshake
//   pix_data             in   16  input pixel
//   rom_addr             out  8   shared ROM address (S1 index register)
//   rom_r/g/b            in   8   ROM data, one clock after rom_addr
//   rgb_valid/rgb_ready  out/in   output handshake
//   rgb_r/g/b            out  8   RGB888 result (registered)
// -----------------------------------------------------------------------------
module cry_rgb_conv
    import cry_pkg::*;
(
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        cry_mode,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    output logic [7:0]  rom_addr,
    input  logic [7:0]  rom_r,
    input  logic [7:0]  rom_g,
    input  logic [7:0]  rom_b,
    output logic        rgb_valid,
    input  logic        rgb_ready,
    output logic [7:0]  rgb_r,
    output logic [7:0]  rgb_g,
    output logic [7:0]  rgb_b
);

    logic        w_adv;
    logic        r_v1, r_mode1;
    logic [15:0] r_data1;
    logic        r_v2, r_mode2;
    logic [15:0] r_data2;
    logic        r_rom_fresh;
    logic [7:0]  r_hold_r, r_hold_g, r_hold_b;
    logic [7:0]  w_rom_r, w_rom_g, w_rom_b;
    logic [7:0]  w_scl_r, w_scl_g, w_scl_b;
    logic [7:0]  w_r, w_g, w_b;
    logic        r_v3;
    logic [7:0]  r_rgb_r, r_rgb_g, r_rgb_b;

    assign w_adv     = !r_v3 || rgb_ready;
    assign pix_ready = w_adv;
    assign rom_addr  = r_data1[CRY_IDX_MSB:CRY_IDX_LSB];
    assign rgb_valid = r_v3;
    assign rgb_r     = r_rgb_r;
    assign rgb_g     = r_rgb_g;
    assign rgb_b     = r_rgb_b;

    // S1: accept the input pixel; its index register drives the ROM address.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_mode1 <= MODE_RGB16;
            r_data1 <= 16'h0000;
        end else if (w_adv) begin
            r_v1    <= pix_valid;
            r_mode1 <= cry_mode;
            r_data1 <= pix_data;
        end else begin
            r_v1    <= r_v1;
            r_mode1 <= r_mode1;
            r_data1 <= r_data1;
        end
    end

    // S2: align mode and Y/RGB16 fields with the ROM data for the same pixel.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_mode2 <= MODE_RGB16;
            r_data2 <= 16'h0000;
        end else if (w_adv) begin
            r_v2    <= r_v1;
            r_mode2 <= r_mode1;
            r_data2 <= r_data1;
        end else begin
            r_v2    <= r_v2;
            r_mode2 <= r_mode2;
            r_data2 <= r_data2;
        end
    end

    // The ROMs keep clocking during a stall, so after the first stalled edge
    // they return data for the S1 pixel, not the S2 one. The S2 copy is kept
    // in r_hold_* from that edge until the pipeline moves again.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_rom_fresh <= 1'b1;
            r_hold_r    <= 8'h00;
            r_hold_g    <= 8'h00;
            r_hold_b    <= 8'h00;
        end else begin
            r_rom_fresh <= w_adv;
            r_hold_r    <= w_rom_r;
            r_hold_g    <= w_rom_g;
            r_hold_b    <= w_rom_b;
        end
    end

    // Select live ROM data or the held copy belonging to the S2 pixel.
    always_comb begin
        w_rom_r = r_hold_r;
        w_rom_g = r_hold_g;
        w_rom_b = r_hold_b;
        if (r_rom_fresh) begin
            w_rom_r = rom_r;
            w_rom_g = rom_g;
            w_rom_b = rom_b;
        end else begin
            w_rom_r = r_hold_r;
            w_rom_g = r_hold_g;
            w_rom_b = r_hold_b;
        end
    end

    cry_scale u_scale_r (.i_comp(w_rom_r), .i_y(r_data2[CRY_Y_MSB:CRY_Y_LSB]), .o_comp(w_scl_r));
    cry_scale u_scale_g (.i_comp(w_rom_g), .i_y(r_data2[CRY_Y_MSB:CRY_Y_LSB]), .o_comp(w_scl_g));
    cry_scale u_scale_b (.i_comp(w_rom_b), .i_y(r_data2[CRY_Y_MSB:CRY_Y_LSB]), .o_comp(w_scl_b));

    // Per-pixel format select between scaled CRY and expanded RGB16.
    always_comb begin
        w_r = 8'h00;
        w_g = 8'h00;
        w_b = 8'h00;
        if (r_mode2 == MODE_CRY) begin
            w_r = w_scl_r;
            w_g = w_scl_g;
            w_b = w_scl_b;
        end else begin
            w_r = expand5(r_data2[RGB16_R_MSB:RGB16_R_LSB]);
            w_g = expand6(r_data2[RGB16_G_MSB:RGB16_G_LSB]);
            w_b = expand5(r_data2[RGB16_B_MSB:RGB16_B_LSB]);
        end
    end

    // S3: registered output stage.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_v3    <= 1'b0;
            r_rgb_r <= 8'h00;
            r_rgb_g <= 8'h00;
            r_rgb_b <= 8'h00;
        end else if (w_adv) begin
            r_v3    <= r_v2;
            r_rgb_r <= w_r;
            r_rgb_g <= w_g;
            r_rgb_b <= w_b;
        end else begin
            r_v3    <= r_v3;
            r_rgb_r <= r_rgb_r;
            r_rgb_g <= r_rgb_g;
            r_rgb_b <= r_rgb_b;
        end
    end

endmodule

// File: tb/tb_cry_rgb_conv.sv
// -----------------------------------------------------------------------------
// tb_cry_rgb_conv
// Directed testbench for cry_rgb_conv with a registered ROM model and an
// output scoreboard.
// -----------------------------------------------------------------------------
module tb_cry_rgb_conv;

    logic        sys_clk   = 1'b0;
    logic        rst       = 1'b1;
    logic        cry_mode  = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [15:0] pix_data  = 16'h0000;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_r = 8'h00, rom_g = 8'h00, rom_b = 8'h00;
    logic        rgb_valid;
    logic        rgb_ready = 1'b1;
    logic [7:0]  rgb_r, rgb_g, rgb_b;

    logic [7:0]  mem_r [256];
    logic [7:0]  mem_g [256];
    logic [7:0]  mem_b [256];

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_out    = 0;
    logic [23:0] sb_q [$];
    logic [23:0] mon_exp;

    cry_rgb_conv dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .cry_mode (cry_mode),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_data (pix_data),
        .rom_addr (rom_addr),
        .rom_r    (rom_r),
        .rom_g    (rom_g),
        .rom_b    (rom_b),
        .rgb_valid(rgb_valid),
        .rgb_ready(rgb_ready),
        .rgb_r    (rgb_r),
        .rgb_g    (rgb_g),
        .rgb_b    (rgb_b)
    );

    always #5 sys_clk = ~sys_clk;

    // Registered ROM model, one clock of latency.
    always @(posedge sys_clk) begin
        rom_r <= mem_r[rom_addr];
        rom_g <= mem_g[rom_addr];
        rom_b <= mem_b[rom_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference conversion.
    function automatic logic [23:0] ref_pix(input logic mode, input logic [15:0] d);
        logic [15:0] pr, pg, pb;
        logic [7:0]  idx, y;
        logic [4:0]  r5, b5;
        logic [5:0]  g6;
        idx = d[15:8];
        y   = d[7:0];
        r5  = d[15:11];
        b5  = d[10:6];
        g6  = d[5:0];
        pr  = 16'(mem_r[idx]) * 16'(y);
        pg  = 16'(mem_g[idx]) * 16'(y);
        pb  = 16'(mem_b[idx]) * 16'(y);
        if (mode) return {pr[15:8], pg[15:8], pb[15:8]};
        else      return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    endfunction

    // Scoreboard: record accepted pixels, compare transferred outputs.
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (pix_valid && pix_ready) sb_q.push_back(ref_pix(cry_mode, pix_data));
            if (rgb_valid && rgb_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_out", 32'd1, 32'd0);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check_eq("out_pix", {8'h00, rgb_r, rgb_g, rgb_b}, {8'h00, mon_exp});
                end
                n_out++;
            end
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    logic        d_mode [6];
    logic [15:0] d_data [6];
    logic [23:0] d_exp  [6];
    logic [15:0] cur;
    logic [23:0] snap;
    logic [7:0]  snap_addr;
    int          base;
    int          p;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_r[i] = 8'(i);
            mem_g[i] = 8'(8'hFF - 8'(i));
            mem_b[i] = 8'(i * 7);
        end
        mem_r[8'h42] = 8'hFF; mem_g[8'h42] = 8'h80; mem_b[8'h42] = 8'h00;
        mem_r[8'h10] = 8'h64; mem_g[8'h10] = 8'hC8; mem_b[8'h10] = 8'h01;

        d_mode = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        d_data = '{16'h42FF, 16'hF83F, 16'h4200, 16'h0000, 16'h0840, 16'h0001};
        d_exp  = '{24'hFE7F00, 24'hFFFF00, 24'h000000, 24'h000000, 24'h080008, 24'h000400};

        // Reset state
        #3;
        check_eq("rst_valid", {31'd0, rgb_valid}, 32'd0);
        check_eq("rst_pready", {31'd0, pix_ready}, 32'd1);
        check_eq("rst_addr", {24'd0, rom_addr}, 32'd0);
        check_eq("rst_rgb", {8'h00, rgb_r, rgb_g, rgb_b}, 32'd0);
        repeat (2) @(posedge sys_clk);
        #1 rst = 1'b0;

        // Single pixels: latency and conversion
        for (int i = 0; i < 6; i++) begin
            cry_mode = d_mode[i]; pix_data = d_data[i]; pix_valid = 1'b1;
            cur = d_data[i];
            step();
            pix_valid = 1'b0;
            check_eq("single_addr", {24'd0, rom_addr}, {24'd0, cur[15:8]});
            check_eq("single_v_e0", {31'd0, rgb_valid}, 32'd0);
            step();
            check_eq("single_v_e1", {31'd0, rgb_valid}, 32'd0);
            step();
            check_eq("single_v_e2", {31'd0, rgb_valid}, 32'd1);
            check_eq("single_pix", {8'h00, rgb_r, rgb_g, rgb_b}, {8'h00, d_exp[i]});
            step();
            check_eq("single_oneshot", {31'd0, rgb_valid}, 32'd0);
        end

        // Streaming: 8 CRY pixels, Y = 0x80 halves each component
        base = n_out;
        for (int k = 0; k < 11; k++) begin
            if (k < 8) begin
                cry_mode = 1'b1; pix_data = {8'(8'h20 + k), 8'h80}; pix_valid = 1'b1;
            end else begin
                pix_valid = 1'b0;
            end
            step();
            if (k >= 2 && k <= 9) begin
                check_eq("stream_valid", {31'd0, rgb_valid}, 32'd1);
                check_eq("stream_r_half", {24'd0, rgb_r}, {24'd0, mem_r[8'(8'h20 + k - 2)] >> 1});
                check_eq("stream_g_half", {24'd0, rgb_g}, {24'd0, mem_g[8'(8'h20 + k - 2)] >> 1});
            end
        end
        check_eq("stream_count", n_out - base, 32'd8);

        // Backpressure: rgb_ready low for 4 cycles mid-stream
        base = n_out;
        p = 0;
        for (int cyc = 0; cyc < 22; cyc++) begin
            rgb_ready = !(cyc >= 4 && cyc < 8);
            pix_valid = (p < 10);
            cry_mode  = p[0];
            pix_data  = {8'(8'h50 + p), 8'(8'h33 + 8'(p * 16))};
            #1;
            if (!rgb_ready) begin
                check_eq("bp_pix_ready", {31'd0, pix_ready}, 32'd0);
                if (cyc == 4) begin
                    snap = {rgb_r, rgb_g, rgb_b};
                    snap_addr = rom_addr;
                end else begin
                    check_eq("bp_freeze_rgb", {8'h00, rgb_r, rgb_g, rgb_b}, {8'h00, snap});
                    check_eq("bp_freeze_addr", {24'd0, rom_addr}, {24'd0, snap_addr});
                    check_eq("bp_freeze_valid", {31'd0, rgb_valid}, 32'd1);
                end
            end
            if (pix_valid && pix_ready) p++;
            step();
        end
        pix_valid = 1'b0;
        rgb_ready = 1'b1;
        check_eq("bp_count", n_out - base, 32'd10);
        check_eq("bp_drained", sb_q.size(), 32'd0);

        // Mixed-mode stream, no bubbles
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                cry_mode = (k % 2 == 0);
                pix_data = (k % 2 == 0) ? 16'h10FF : 16'hFFFF;
                pix_valid = 1'b1;
            end else begin
                pix_valid = 1'b0;
            end
            step();
            if (k >= 2) check_eq("mix_valid", {31'd0, rgb_valid}, 32'd1);
            if (k == 2) check_eq("mix_cry", {8'h00, rgb_r, rgb_g, rgb_b}, 32'h0063C700);
            if (k == 3) check_eq("mix_rgb16", {8'h00, rgb_r, rgb_g, rgb_b}, 32'h00FFFFFF);
        end
        step();

        // Async reset mid-stall with 3 pixels in flight
        rgb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cry_mode = 1'b1; pix_data = {8'(8'h70 + k), 8'hC0}; pix_valid = 1'b1;
            step();
        end
        pix_valid = 1'b0;
        check_eq("stall_valid", {31'd0, rgb_valid}, 32'd1);
        step();
        #2 rst = 1'b1;
        sb_q.delete();
        #1;
        check_eq("arst_valid", {31'd0, rgb_valid}, 32'd0);
        check_eq("arst_rgb", {8'h00, rgb_r, rgb_g, rgb_b}, 32'd0);
        check_eq("arst_addr", {24'd0, rom_addr}, 32'd0);
        check_eq("arst_pready", {31'd0, pix_ready}, 32'd1);
        @(posedge sys_clk);
        #3 rst = 1'b0;
        rgb_ready = 1'b1;
        base = n_out;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("post_rst_idle", {31'd0, rgb_valid}, 32'd0);
        end
        check_eq("post_rst_count", n_out - base, 32'd0);

        // First pixel after reset
        cry_mode = 1'b0; pix_data = 16'hFFFF; pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        step();
        step();
        check_eq("post_rst_valid", {31'd0, rgb_valid}, 32'd1);
        check_eq("post_rst_pix", {8'h00, rgb_r, rgb_g, rgb_b}, 32'h00FFFFFF);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
